// File: rtl/decoder_pkg.sv
// decoder_pkg -- shared widths, types and the index decode helper for the
// decoder3to8_seq block.
//   IDX_W    : width of an encoded index (3)
//   OUT_W    : width of the one-hot word (8)
//   MASK_ALL : value of the serviced mask once every line has been delivered
package decoder_pkg;

  localparam int IDX_W = 3;
  localparam int OUT_W = 8;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [OUT_W-1:0] onehot_t;

  localparam onehot_t MASK_ALL = 8'hFF;

  // Set exactly the bit selected by the index.
  function automatic onehot_t decode_idx(input idx_t idx);
    onehot_t w_word;
    w_word      = '0;
    w_word[idx] = 1'b1;
    return w_word;
  endfunction

endpackage

// File: rtl/decoder3to8_seq_if.sv
// decoder3to8_seq_if -- handshake and mask bundle for decoder3to8_seq.
//   in_valid/in_idx/in_ready     : upstream index stream
//   out_valid/out_onehot/out_ready: downstream one-hot stream
//   clr_mask/mask/mask_full      : serviced-mask control and status
// Handshake: a word moves on a rising clk edge where valid=1 and ready=1;
// the producer holds valid and data steady until that edge, and ready never
// depends combinationally on valid.
// Modports: master = upstream/downstream environment, slave = the block.
interface decoder3to8_seq_if;
  import decoder_pkg::*;

  logic    in_valid;
  idx_t    in_idx;
  logic    in_ready;
  logic    out_valid;
  onehot_t out_onehot;
  logic    out_ready;
  logic    clr_mask;
  onehot_t mask;
  logic    mask_full;

  modport master (
    output in_valid, in_idx, out_ready, clr_mask,
    input  in_ready, out_valid, out_onehot, mask, mask_full
  );

  modport slave (
    input  in_valid, in_idx, out_ready, clr_mask,
    output in_ready, out_valid, out_onehot, mask, mask_full
  );

endinterface

// File: rtl/decoder3to8_seq_skid.sv
// skid_buffer -- two-entry (output register + skid register) ready/valid
// pipeline stage with a fully registered upstream ready.
//   clk, rst     : clock, asynchronous active-high reset
//   i_valid      : upstream data valid
//   i_data[W]    : upstream data
//   o_ready      : registered ready, equal to NOT skid_full (0 during reset)
//   o_valid      : output register holds data
//   o_data[W]    : output register contents
//   i_out_ready  : downstream accepts o_data
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_out_ready
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;
  logic         r_in_ready;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_skid_valid_nxt;

  assign w_in_xfer  = i_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & i_out_ready;

  // The skid register fills only when the output register is held by
  // backpressure, and drains on any output transfer.
  always_comb begin
    w_skid_valid_nxt = r_skid_valid;
    if (r_skid_valid) begin
      w_skid_valid_nxt = !w_out_xfer;
    end else begin
      w_skid_valid_nxt = r_out_valid && !w_out_xfer && w_in_xfer;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      if (r_skid_valid) begin
        // in_ready is low here, so no new word can arrive.
        if (w_out_xfer) begin
          r_out_data <= r_skid_data;
        end
      end else if (!r_out_valid || w_out_xfer) begin
        // Output register free (or being emptied): load directly, no bubble.
        r_out_valid <= w_in_xfer;
        if (w_in_xfer) begin
          r_out_data <= i_data;
        end
      end else if (w_in_xfer) begin
        r_skid_data <= i_data;
      end
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule

// File: rtl/decoder3to8_seq.sv
// decoder3to8_seq -- registered 3-to-8 decoder with ready/valid flow control
// and an optional sticky mask of delivered one-hot words.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : decoder3to8_seq_if.slave (index in, one-hot out, mask control)
// Optional feature macro: DECODER3TO8_SEQ_MASK_EN enables the mask register;
// without it mask reads 8'h00, mask_full reads 0 and clr_mask is ignored.
module decoder3to8_seq
  import decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  decoder3to8_seq_if.slave  bus
);

  logic    w_out_valid;
  idx_t    w_out_idx;
  logic    w_in_ready;
  onehot_t w_onehot;

  // Store the raw index; decoding happens on the stored value.
  skid_buffer #(.W(IDX_W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (bus.in_valid),
    .i_data      (bus.in_idx),
    .o_ready     (w_in_ready),
    .o_valid     (w_out_valid),
    .o_data      (w_out_idx),
    .i_out_ready (bus.out_ready)
  );

  assign w_onehot       = w_out_valid ? decode_idx(w_out_idx) : '0;
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_onehot = w_onehot;

`ifdef DECODER3TO8_SEQ_MASK_EN
  onehot_t r_mask;
  logic    w_out_xfer;

  assign w_out_xfer = w_out_valid & bus.out_ready;

  // Clear takes effect before the delivered word is OR-ed in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
    end else if (bus.clr_mask) begin
      r_mask <= w_out_xfer ? w_onehot : '0;
    end else if (w_out_xfer) begin
      r_mask <= r_mask | w_onehot;
    end
  end

  assign bus.mask      = r_mask;
  assign bus.mask_full = (r_mask == MASK_ALL);
`else
  logic w_unused_clr;
  assign w_unused_clr  = bus.clr_mask;
  assign bus.mask      = '0;
  assign bus.mask_full = 1'b0;
`endif

endmodule

// File: doc/decoder3to8_seq.md
DECODER3TO8_SEQ -- requirements
Module: decoder3to8_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, asynchronous active-high reset).
REQ-002 in_valid  input  1  Upstream index valid.
REQ-003 in_idx  input  3  Encoded index, 0..7, as produced by the 8-to-3 priority encoder.
REQ-004 in_ready  output  1  Block can accept an index this cycle.
REQ-005 out_valid  output  1  out_onehot holds a decoded word.
REQ-006 out_onehot  output  8  One-hot decode of the accepted index (bit in_idx set).
REQ-007 out_ready  input  1  Downstream accepts out_onehot.
REQ-008 clr_mask  input  1  Synchronous clear of the serviced mask.
REQ-009 mask  output  8  Sticky OR of all delivered one-hot words.
REQ-010 mask_full  output  1  High when mask == 8'hFF.

Function
REQ-011 An input transfer SHALL occur on any rising clk edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on any rising clk edge with out_valid=1 and out_ready=1.
REQ-012 The datapath SHALL be a main output register plus one skid register, holding at most 2 entries.
REQ-013 Latency SHALL be 1 cycle: an index accepted into an empty block appears on out_valid/out_onehot the next cycle.
REQ-014 in_ready SHALL be registered and equal NOT skid_full, with no combinational path from out_ready.
REQ-015 Throughput SHALL be one word per cycle while out_ready=1.
REQ-016 When out_valid=1 and out_ready=0, an accepted input SHALL go to the skid register and in_ready SHALL deassert next cycle.
REQ-017 When the skid register is full, an output transfer SHALL move the skid entry to the output register, and in_ready SHALL reassert next cycle.
REQ-018 Simultaneous input and output transfers with an empty skid register SHALL replace the output register directly, with no bubble.
REQ-019 Order SHALL be preserved: FIFO, no drops, no duplicates.
REQ-020 out_onehot SHALL be exactly 8'h00 whenever out_valid=0, and exactly one bit SHALL be set whenever out_valid=1.
REQ-021 out_onehot and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 On an output transfer, mask SHALL become mask | out_onehot.
REQ-023 clr_mask=1 without an output transfer SHALL set mask to 8'h00.
REQ-024 clr_mask=1 coincident with an output transfer SHALL set mask to out_onehot (clear first, then set).
REQ-025 mask_full SHALL be combinational from mask.
REQ-026 in_idx SHALL be sampled only on an input transfer; its value is don't-care otherwise.

Reset
REQ-027 Asserting rst SHALL immediately force out_valid=0, out_onehot=8'h00, skid empty, mask=8'h00, mask_full=0 and in_ready=0.
REQ-028 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-029 rst asserted mid-transfer SHALL discard both stored entries; no partial word is delivered afterward.

Configuration
REQ-030 Macro DECODER3TO8_SEQ_MASK_EN defined: REQ-022..REQ-025 SHALL be implemented.
REQ-031 Macro DECODER3TO8_SEQ_MASK_EN undefined:
- mask SHALL be tied to 8'h00 and mask_full to 0;
- clr_mask SHALL be ignored;
- no mask flops SHALL be synthesised;
- port list SHALL be unchanged.

Structure
REQ-032 Shared package decoder_pkg SHALL define IDX_W=3, OUT_W=8 and MASK_ALL=8'hFF, plus the typedefs idx_t and onehot_t.
REQ-033 The skid logic SHALL be a sub-module skid_buffer, parameterised by data width and instantiated with width IDX_W.
REQ-034 Decode SHALL occur after the skid buffer, on the stored index.
REQ-035 No latches; all flops SHALL use asynchronous reset on rst.

Verification
REQ-036 Reset check: rst pulse mid-stream with 2 entries held -> out_valid=0, out_onehot=00, mask=00 within the same cycle; in_ready=1 one edge after release; held entries never appear.
REQ-037 Streaming: idx 0,1,...,7 on consecutive cycles with out_ready=1 -> out_onehot 01,02,04,...,80 each one cycle later; in_ready never drops; mask_full=1 after the 8th transfer.
REQ-038 Backpressure: out_ready=0 while idx 5 then 2 are sent -> out_onehot=20 held stable; in_ready=0 after the second accept; out_ready=1 -> 20 then 04 delivered in order.
REQ-039 Mask clear collision: mask=8'h0F, clr_mask=1 on the same edge as delivering 8'h40 -> mask=8'h40, mask_full=0.
REQ-040 Randomised ready/valid, 10k transfers -> scoreboard matches in order; out_onehot has exactly one bit set when valid and is 00 when idle.
REQ-041 Build without DECODER3TO8_SEQ_MASK_EN, rerun REQ-037 -> mask stays 00, mask_full stays 0, datapath results identical.
